// File: rtl/entry_exit_detector_pkg.sv
// Shared definitions for the doorway entry/exit detector.
//   state_t  : FSM state encoding, also driven out on State for the LED/debug path
//   event_t  : the single event decided per cycle, so that at most one pulse
//              output can ever be high
//   *_DEF    : default debounce depth, timeout and timeout-counter width, reused
//              by the integration level
package entry_exit_detector_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        EN1  = 3'd1,
        EN2  = 3'd2,
        EN3  = 3'd3,
        EX1  = 3'd4,
        EX2  = 3'd5,
        EX3  = 3'd6,
        WAIT = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        EV_NONE   = 3'd0,
        EV_ENTER  = 3'd1,
        EV_EXIT   = 3'd2,
        EV_REJECT = 3'd3,
        EV_ABORT  = 3'd4
    } event_t;

    localparam int DB_CYCLES_DEF = 4;
    localparam int TIMEOUT_DEF   = 255;
    localparam int TW_DEF        = 8;

    // Partial-crossing states are the only ones subject to the timeout.
    function automatic logic in_crossing(state_t s);
        return (s != IDLE) && (s != WAIT);
    endfunction

endpackage

// File: rtl/entry_exit_detector_sensor_filter.sv
// sensor_filter: two-flop synchroniser followed by a debounce filter.
// The filtered output only takes a new value after the synchronised input has
// differed from it for DB_CYCLES consecutive cycles; any matching cycle restarts
// the count.
//   i_clock : system clock
//   i_clear : asynchronous active-high clear
//   i_raw   : raw sensor input, asynchronous to i_clock
//   o_filt  : debounced, synchronous sensor value
module sensor_filter #(
    parameter int DB_CYCLES = 4
) (
    input  logic i_clock,
    input  logic i_clear,
    input  logic i_raw,
    output logic o_filt
);

    localparam int CW = $clog2(DB_CYCLES + 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_filt;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clock or posedge i_clear) begin
        if (i_clear) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_filt  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_filt) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DB_CYCLES - 1)) begin
                // this is the DB_CYCLES-th consecutive differing cycle
                r_filt <= r_sync2;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_filt = r_filt;

endmodule

// File: rtl/entry_exit_detector.sv
// entry_exit_detector: turns the outer (Sens_Out) and inner (Sens_In) doorway
// beams into clean one-cycle Enter/Exit events for the occupancy counter, gated
// by the counter's Full/Empty status.
//   Clock       : system clock, rising edge
//   Clear       : asynchronous active-high reset
//   Enable      : 1 = detection active, 0 = FSM held in IDLE, no events
//   Sens_Out    : raw outer beam (1 = broken)
//   Sens_In     : raw inner beam (1 = broken)
//   Full/Empty  : counter status; blocks entries / exits respectively
//   Enter_Pulse : completed, accepted entry
//   Exit_Pulse  : completed, accepted exit
//   Reject      : crossing completed while blocked
//   Abort       : illegal sequence or timeout
//   Busy        : State != IDLE
//   State       : current FSM state
//
// state | meaning (pair = filtered {outer, inner})
// IDLE  | doorway clear, pair 00
// EN1   | entry started, outer only (10)
// EN2   | entry, both beams (11)
// EN3   | entry, inner only (01)
// EX1   | exit started, inner only (01)
// EX2   | exit, both beams (11)
// EX3   | exit, outer only (10)
// WAIT  | after abort, hold until doorway clears (00); no timeout
module entry_exit_detector
    import entry_exit_detector_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF,
    parameter int TW        = TW_DEF
) (
    input  logic       Clock,
    input  logic       Clear,
    input  logic       Enable,
    input  logic       Sens_Out,
    input  logic       Sens_In,
    input  logic       Full,
    input  logic       Empty,
    output logic       Enter_Pulse,
    output logic       Exit_Pulse,
    output logic       Reject,
    output logic       Abort,
    output logic       Busy,
    output logic [2:0] State
);

    logic          w_filt_o;
    logic          w_filt_i;
    logic [1:0]    w_pair;
    state_t        r_state;
    state_t        w_next;
    event_t        w_event;
    logic [TW-1:0] r_tmo;
    logic          r_enter;
    logic          r_exit;
    logic          r_reject;
    logic          r_abort;

    sensor_filter #(.DB_CYCLES(DB_CYCLES)) u_filt_out (
        .i_clock (Clock),
        .i_clear (Clear),
        .i_raw   (Sens_Out),
        .o_filt  (w_filt_o)
    );

    sensor_filter #(.DB_CYCLES(DB_CYCLES)) u_filt_in (
        .i_clock (Clock),
        .i_clear (Clear),
        .i_raw   (Sens_In),
        .o_filt  (w_filt_i)
    );

    assign w_pair = {w_filt_o, w_filt_i};

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            r_state  <= IDLE;
            r_tmo    <= '0;
            r_enter  <= 1'b0;
            r_exit   <= 1'b0;
            r_reject <= 1'b0;
            r_abort  <= 1'b0;
        end else begin
            r_state  <= w_next;
            if ((w_next != r_state) || !in_crossing(r_state)) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + 1'b1;
            end
            r_enter  <= (w_event == EV_ENTER);
            r_exit   <= (w_event == EV_EXIT);
            r_reject <= (w_event == EV_REJECT);
            r_abort  <= (w_event == EV_ABORT);
        end
    end

    always_comb begin
        w_next  = r_state;
        w_event = EV_NONE;
        if (!Enable) begin
            w_next = IDLE;
        end else begin
            unique case (r_state)
                IDLE: case (w_pair)
                    2'b10:   w_next = EN1;
                    2'b01:   w_next = EX1;
                    2'b11:   begin w_next = WAIT; w_event = EV_ABORT; end
                    default: w_next = IDLE;
                endcase
                EN1: case (w_pair)
                    2'b11:   w_next = EN2;
                    2'b00:   w_next = IDLE;
                    2'b01:   w_next = EN3;
                    default: w_next = EN1;
                endcase
                EN2: case (w_pair)
                    2'b01:   w_next = EN3;
                    2'b10:   w_next = EN1;
                    2'b00:   begin w_next = IDLE; w_event = EV_ABORT; end
                    default: w_next = EN2;
                endcase
                EN3: case (w_pair)
                    2'b00:   begin
                        w_next  = IDLE;
                        w_event = Full ? EV_REJECT : EV_ENTER;
                    end
                    2'b11:   w_next = EN2;
                    2'b10:   begin w_next = WAIT; w_event = EV_ABORT; end
                    default: w_next = EN3;
                endcase
                EX1: case (w_pair)
                    2'b11:   w_next = EX2;
                    2'b00:   w_next = IDLE;
                    2'b10:   w_next = EX3;
                    default: w_next = EX1;
                endcase
                EX2: case (w_pair)
                    2'b10:   w_next = EX3;
                    2'b01:   w_next = EX1;
                    2'b00:   begin w_next = IDLE; w_event = EV_ABORT; end
                    default: w_next = EX2;
                endcase
                EX3: case (w_pair)
                    2'b00:   begin
                        w_next  = IDLE;
                        w_event = Empty ? EV_REJECT : EV_EXIT;
                    end
                    2'b11:   w_next = EX2;
                    2'b01:   begin w_next = WAIT; w_event = EV_ABORT; end
                    default: w_next = EX3;
                endcase
                WAIT: begin
                    if (w_pair == 2'b00) w_next = IDLE;
                end
            endcase
            // Timeout only fires when the pair asked to stay; any real
            // transition in the same cycle takes priority.
            if ((w_next == r_state) && in_crossing(r_state) &&
                (r_tmo == TW'(TIMEOUT - 1))) begin
                w_next  = WAIT;
                w_event = EV_ABORT;
            end
        end
    end

    assign Enter_Pulse = r_enter;
    assign Exit_Pulse  = r_exit;
    assign Reject      = r_reject;
    assign Abort       = r_abort;
    assign Busy        = (r_state != IDLE);
    assign State       = r_state;

endmodule

// File: tb/tb_entry_exit_detector.sv
module tb_entry_exit_detector;

    localparam int DB = 4;
    localparam int TO = 255;

    logic       Clock = 1'b0;
    logic       Clear, Enable, Sens_Out, Sens_In, Full, Empty;
    logic       Enter_Pulse, Exit_Pulse, Reject, Abort, Busy;
    logic [2:0] State;

    entry_exit_detector dut (
        .Clock       (Clock),
        .Clear       (Clear),
        .Enable      (Enable),
        .Sens_Out    (Sens_Out),
        .Sens_In     (Sens_In),
        .Full        (Full),
        .Empty       (Empty),
        .Enter_Pulse (Enter_Pulse),
        .Exit_Pulse  (Exit_Pulse),
        .Reject      (Reject),
        .Abort       (Abort),
        .Busy        (Busy),
        .State       (State)
    );

    always #5 Clock = ~Clock;

    typedef struct { int cyc; int st; } cyc_t;
    typedef struct { int cyc; int code; } evt_t;   // 1 enter 2 exit 3 reject 4 abort

    cyc_t q_cyc[$];
    evt_t q_evt[$];
    int   total = 0;
    int   bad   = 0;

    int n_enter = 0, n_exit = 0, n_reject = 0, n_abort = 0;
    int last_enter = -1000, last_abort = -1000;

    bit g_en = 1'b1, g_full = 1'b0, g_empty = 1'b0;

    // reference model: raw sample history, filtered pair, crossing progress
    bit h_o[$], h_i[$];
    bit f_o, f_i;
    int mode;      // 0 doorway clear, 1 crossing in progress, 2 waiting for clear
    int dir;       // 0 entering, 1 exiting
    int pos;       // progress through the crossing, 1..3
    int t_enter;   // cycle at which the current state was entered
    int n = 0;     // index of the next rising edge

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, n);
        end
    endtask

    function automatic int enc();
        if (mode == 0) return 0;
        if (mode == 2) return 7;
        return dir * 3 + pos;
    endfunction

    // position of a pair along the crossing sequence: lead beam only = 1,
    // both = 2, trailing beam only = 3, none = 0
    function automatic int seq_pos(int d, bit o, bit i);
        bit a, b;
        a = d ? i : o;
        b = d ? o : i;
        if (a && !b) return 1;
        if (a && b)  return 2;
        if (!a && b) return 3;
        return 0;
    endfunction

    // filtered value flips once the last DB synchronised samples all disagree;
    // the sample used at edge k is the raw value taken two edges earlier
    function automatic bit debounce(bit h[$], bit f);
        for (int k = 3; k < DB + 3; k++)
            if (h[h.size() - k] == f) return f;
        return !f;
    endfunction

    task automatic model_reset();
        h_o = {}; h_i = {};
        for (int k = 0; k < DB + 3; k++) begin h_o.push_back(1'b0); h_i.push_back(1'b0); end
        f_o = 1'b0; f_i = 1'b0; mode = 0; dir = 0; pos = 0; t_enter = n;
    endtask

    task automatic model_edge(bit so, bit si);
        int ev, prev, k;
        ev = 0;
        prev = enc();
        if (!g_en) begin
            mode = 0;
        end else if (mode == 0) begin
            if (f_o && f_i) begin mode = 2; ev = 4; end
            else if (f_o || f_i) begin mode = 1; dir = f_i ? 1 : 0; pos = 1; end
        end else if (mode == 1) begin
            k = seq_pos(dir, f_o, f_i);
            if (k == pos) begin
                if (n - t_enter == TO) begin mode = 2; ev = 4; end
            end else if (k == 0) begin
                mode = 0;
                if (pos == 2) ev = 4;
                else if (pos == 3) ev = (dir ? g_empty : g_full) ? 3 : (dir ? 2 : 1);
            end else if (k - pos == -2) begin
                mode = 2; ev = 4;
            end else begin
                pos = k;
            end
        end else begin
            if (!f_o && !f_i) mode = 0;
        end
        if (enc() != prev) t_enter = n;
        h_o.push_back(so); h_i.push_back(si);
        if (h_o.size() > 16) begin void'(h_o.pop_front()); void'(h_i.pop_front()); end
        f_o = debounce(h_o, f_o);
        f_i = debounce(h_i, f_i);
        q_cyc.push_back('{n, enc()});
        if (ev != 0) q_evt.push_back('{n, ev});
    endtask

    task automatic step(bit so, bit si, bit clr);
        @(negedge Clock);
        Clear = clr; Sens_Out = so; Sens_In = si;
        Enable = g_en; Full = g_full; Empty = g_empty;
        if (clr) begin
            model_reset();
            q_cyc.push_back('{n, 0});
        end else begin
            model_edge(so, si);
        end
        n++;
    endtask

    task automatic seg(bit so, bit si, int len);
        for (int k = 0; k < len; k++) step(so, si, 1'b0);
    endtask

    task automatic entry(); seg(1,0,10); seg(1,1,10); seg(0,1,10); seg(0,0,15); endtask
    task automatic leave(); seg(0,1,10); seg(1,1,10); seg(1,0,10); seg(0,0,15); endtask

    // monitor: compares every cycle's state and pops the event queue whenever
    // the DUT shows a pulse
    initial begin
        cyc_t c;
        evt_t e;
        int   code;
        forever begin
            @(posedge Clock);
            #1;
            if (q_cyc.size() != 0) begin
                c = q_cyc.pop_front();
                check("state", State, c.st);
                check("busy", Busy, (c.st != 0));
                check("onehot", $countones({Enter_Pulse, Exit_Pulse, Reject, Abort}) <= 1, 1);
                code = Enter_Pulse ? 1 : Exit_Pulse ? 2 : Reject ? 3 : Abort ? 4 : 0;
                if (code == 1) begin n_enter++; last_enter = c.cyc; end
                if (code == 2) n_exit++;
                if (code == 3) n_reject++;
                if (code == 4) begin n_abort++; last_abort = c.cyc; end
                if (code != 0) begin
                    if (q_evt.size() == 0) begin
                        check("unexpected_pulse", code, 0);
                    end else begin
                        e = q_evt.pop_front();
                        check("pulse_kind", code, e.code);
                        check("pulse_cycle", c.cyc, e.cyc);
                    end
                end else if (q_evt.size() != 0 && q_evt[0].cyc <= c.cyc) begin
                    e = q_evt.pop_front();
                    check("missed_pulse", 0, e.code);
                end
            end
        end
    end

    initial begin
        int ref_cyc, b_enter, b_exit, b_reject, b_abort, guard;
        Clear = 1'b1; Enable = 1'b1; Sens_Out = 1'b0; Sens_In = 1'b0; Full = 1'b0; Empty = 1'b0;
        model_reset();
        for (int k = 0; k < 3; k++) step(0, 0, 1'b1);
        #1;
        check("reset_outputs", {Enter_Pulse, Exit_Pulse, Reject, Abort, Busy, State}, 0);
        seg(0, 0, 5);

        // clean entry, enter pulse 7 cycles after the inner beam clears
        b_enter = n_enter; b_abort = n_abort;
        seg(1,0,10); seg(1,1,10); seg(0,1,10);
        ref_cyc = n - 1;
        seg(0,0,15);
        check("entry_count", n_enter - b_enter, 1);
        check("entry_latency", last_enter - ref_cyc, 7);
        check("entry_no_abort", n_abort - b_abort, 0);

        // clean exit
        b_exit = n_exit; b_enter = n_enter;
        leave();
        check("exit_count", n_exit - b_exit, 1);
        check("exit_no_enter", n_enter - b_enter, 0);

        // back-out and short glitch
        b_enter = n_enter; b_exit = n_exit; b_abort = n_abort;
        seg(1,0,10); seg(0,0,15);
        seg(0,1,3);  seg(0,0,12);
        check("backout_quiet", (n_enter - b_enter) + (n_exit - b_exit) + (n_abort - b_abort), 0);

        // blocked crossings
        b_reject = n_reject; b_enter = n_enter; b_exit = n_exit;
        g_full = 1'b1;  entry(); g_full = 1'b0;
        g_empty = 1'b1; leave(); g_empty = 1'b0;
        check("blocked_rejects", n_reject - b_reject, 2);
        check("blocked_no_pulse", (n_enter - b_enter) + (n_exit - b_exit), 0);

        // timeout: EN1 is entered 7 edges after the raw rise, abort 255 later
        b_abort = n_abort;
        ref_cyc = n - 1;
        seg(1,0,300);
        check("timeout_state_wait", State, 7);
        seg(0,0,15);
        check("timeout_aborts", n_abort - b_abort, 1);
        check("timeout_latency", last_abort - ref_cyc, 7 + TO);

        // asynchronous clear in the middle of an entry
        seg(1,0,10);
        guard = 0;
        while (enc() != 2 && guard < 40) begin step(1, 1, 1'b0); guard++; end
        check("reached_en2", enc(), 2);
        step(1, 1, 1'b0);
        @(negedge Clock);
        Clear = 1'b1;
        #1;
        check("clear_immediate", {Enter_Pulse, Exit_Pulse, Reject, Abort, Busy, State}, 0);
        for (int k = 0; k < 2; k++) step(1, 1, 1'b1);
        step(0, 0, 1'b1);
        b_enter = n_enter; b_abort = n_abort;
        seg(0,0,15);
        check("after_clear_quiet", (n_enter - b_enter) + (n_abort - b_abort), 0);

        // disabled: full entry produces nothing
        b_enter = n_enter;
        g_en = 1'b0; entry(); g_en = 1'b1;
        seg(0,0,5);
        check("disabled_no_enter", n_enter - b_enter, 0);

        // randomized segments
        for (int s = 0; s < 160; s++) begin
            g_full  = ($urandom_range(0, 3) == 0);
            g_empty = ($urandom_range(0, 3) == 0);
            g_en    = ($urandom_range(0, 15) != 0);
            seg(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 20));
        end
        g_en = 1'b1; g_full = 1'b0; g_empty = 1'b0;
        seg(0, 0, 25);
        check("leftover_events", q_evt.size(), 0);

        @(negedge Clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
